dbnc_event_dev: RTL and testbench
=================================

Name: dbnc_event_dev

Overview:
- Memory-mapped debounced input device, parametrised in channel count (NCH) and event depth.
- Each debounced change of the input vector is queued as an event in a small FIFO.
- The CPU pops events through a data register; status, interrupt enable and a sticky overrun flag live in a control register.
- Sits on the processor's ABUS/DBUS I/O bus alongside the other memory-mapped devices.

Parameters:
- BITS, 32, bus width of ABUS/DBUS.
- BASE, 32'hF0000010, address of the DATA register; CTRL is at BASE+32'h100.
- NCH, 10, number of input channels (1..BITS-5).
- DEPTH, 4, event FIFO entries (power of two, >=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to commit (>=1).
- READYBIT, 0; OVERRUNBIT, 2; IEBIT, 8: CTRL bit positions.

Ports:
- CLK  in  1  system clock; all state on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- ABUS  in  BITS  address bus.
- DBUS  inout  BITS  data bus; driven only on a selected read, else high-Z.
- WE  in  1  write enable (1 = write, 0 = read).
- FLUSH  in  1  pipeline flush; when high, masks all selects.
- IN  in  NCH  raw asynchronous-ish inputs (switches/keys).
- INTR  out  1  = IE.
- IRQ  out  1  = IE && READY.
- DEBUG  out  NCH+4  {committed value, IE, OVERRUN, READY, holding}.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty, IE=0, OVERRUN=0, counter=0, holding=0.
  - cand and committed both <= IN, so no event is generated on reset release.
  - Reset mid-debounce or with a non-empty FIFO discards everything.
- Selects:
  - selD = ABUS==BASE && !FLUSH.
  - selC = ABUS==BASE+32'h100 && !FLUSH.
  - Reads are combinational onto DBUS in the same cycle; side effects occur at the next posedge.
- Debounce:
  - If IN != cand: cand<=IN, counter<=0, holding<=1.
  - Else if holding: counter increments. When counter==DEBOUNCE_CYCLES-1, commit and set holding<=0.
  - A commit therefore needs DEBOUNCE_CYCLES consecutive cycles with IN == cand.
  - On commit, if cand != committed: committed<=cand and push cand. An equal value (glitch returned) is not pushed.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it does not wrap while holding.
- FIFO: head/tail pointers of $clog2(DEPTH) bits plus a count of $clog2(DEPTH)+1 bits; pointers wrap mod DEPTH.
  - READY = count != 0.
  - Push while full (and no pop that cycle): event dropped, oldest entries kept, OVERRUN<=1.
  - Simultaneous push and pop: both occur, count unchanged, no overrun even when full.
  - Pop with empty FIFO: no pointer change.
- DATA read: DBUS = zero-extended FIFO head if READY, else zero-extended committed value. Pops one entry at the posedge when READY.
- DATA write: ignored.
- CTRL read: IE at IEBIT, OVERRUN at OVERRUNBIT, READY at READYBIT, count (4 bits, saturating at 15) at [15:12], all other bits 0.
- CTRL write:
  - IE <= DBUS[IEBIT].
  - OVERRUN cleared only if DBUS[OVERRUNBIT]==0 (write-0-to-clear).
  - If an overrun sets in the same cycle as a clearing write, set wins.
  - READY and count are read-only.
- Output latency: a commit becomes visible on READY/IRQ one cycle after the commit edge.

Optional Feature:
- DBNC_EDGE_MASK_EN
  - Defined: adds a MASK register (NCH bits) at BASE+32'h200, readable and writable, reset value all-ones. A commit pushes only if (cand ^ committed) & MASK is nonzero; committed always updates.
  - Undefined: no MASK register; BASE+32'h200 is unselected (DBUS stays high-Z); every changed commit pushes.

Decomposition:
- Shared io_pkg: register offsets (DATA 'h0, CTRL 'h100, MASK 'h200), bit positions READYBIT, OVERRUNBIT, IEBIT, COUNT field LSB 12.
- Sub-module io_event_fifo (params W, DEPTH): push/pop/full/empty/count/head. It is reusable by the next keypad and timer devices.

Test Plan (NCH=10, DEPTH=4, DEBOUNCE_CYCLES=8):
- Reset with IN=10'h155, release, wait 50 cycles -> READY=0, IRQ=0, DATA read returns 32'h155.
- IN 10'h000 -> 10'h003 held 8 cycles -> READY=1 on cycle 9; with IE=1, IRQ=1; DATA read returns 32'h003; READY=0 the next cycle.
- IN toggles 10'h001 for 5 cycles then back to 10'h000 -> no event, READY stays 0; holding drops after 8 stable cycles.
- 5 distinct stable changes with no reads -> count=4 (CTRL[15:12]), OVERRUN=1, reads return the first 4 values in order. CTRL write 32'h100 clears OVERRUN and keeps IE=1.
- FIFO full plus a DATA read on the same cycle as a commit -> count stays 4, OVERRUN stays 0, the newest event lands at the tail.
- DBNC_EDGE_MASK_EN with MASK=10'h002 and IN changing bit0 only -> no push, DATA read returns the new committed value; a bit1 change -> push.

Source files
------------

// File: rtl/io_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_pkg                                                           |
// | Shared register map and CTRL bit layout for memory-mapped I/O.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package io_pkg;

  localparam logic [31:0] c_DATA_OFF   = 32'h0000_0000;
  localparam logic [31:0] c_CTRL_OFF   = 32'h0000_0100;
  localparam logic [31:0] c_MASK_OFF   = 32'h0000_0200;

  localparam int c_READYBIT   = 0;
  localparam int c_OVERRUNBIT = 2;
  localparam int c_IEBIT      = 8;
  localparam int c_COUNT_LSB  = 12;

  function automatic logic [3:0] sat_count4(input int unsigned n);
    return (n > 15) ? 4'hF : n[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_event_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | io_event_fifo                                                    |
// | Small event FIFO; a push into a full FIFO is accepted only when  |
// | a pop happens in the same cycle.                                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module io_event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_FULL);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  // when full, the slot being popped is the one the push overwrites
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dbnc_event_dev.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dbnc_event_dev                                                   |
// | Debounced input device queueing committed changes as events.     |
// | Optional: DBNC_EDGE_MASK_EN adds a per-channel MASK register.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dbnc_event_dev
  import io_pkg::*;
#(
  parameter int unsigned     BITS            = 32,
  parameter logic [BITS-1:0] BASE            = 32'hF000_0010,
  parameter int unsigned     NCH             = 10,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     DEBOUNCE_CYCLES = 1000000,
  parameter int              READYBIT        = c_READYBIT,
  parameter int              OVERRUNBIT      = c_OVERRUNBIT,
  parameter int              IEBIT           = c_IEBIT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  input  logic            FLUSH,
  input  logic [NCH-1:0]  IN,
  output logic            INTR,
  output logic            IRQ,
  output logic [NCH+3:0]  DEBUG
);

  localparam int              c_CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BITS-1:0] c_ADDR_DATA = BASE + BITS'(c_DATA_OFF);
  localparam logic [BITS-1:0] c_ADDR_CTRL = BASE + BITS'(c_CTRL_OFF);

  logic [NCH-1:0]            r_cand;
  logic [NCH-1:0]            r_committed;
  logic [c_CW-1:0]           r_cnt;
  logic                      r_holding;
  logic                      r_ie;
  logic                      r_ovr;

  logic                      w_sel_d;
  logic                      w_sel_c;
  logic                      w_sel_m;
  logic                      w_commit;
  logic                      w_push_req;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_ready;
  logic                      w_wr_c;
  logic                      w_ovr_set;
  logic [NCH-1:0]            w_head;
  logic [$clog2(DEPTH):0]    w_count;
  logic [BITS-1:0]           w_rdata;
  logic                      w_unused_ok;

  assign w_sel_d  = (ABUS == c_ADDR_DATA) && !FLUSH;
  assign w_sel_c  = (ABUS == c_ADDR_CTRL) && !FLUSH;
  assign w_wr_c   = w_sel_c && WE;
  assign w_ready  = !w_empty;
  assign w_pop    = w_sel_d && !WE && w_ready;
  assign w_commit = (IN == r_cand) && r_holding && (r_cnt == c_CNT_LAST);

`ifdef DBNC_EDGE_MASK_EN
  localparam logic [BITS-1:0] c_ADDR_MASK = BASE + BITS'(c_MASK_OFF);
  logic [NCH-1:0] r_mask;

  assign w_sel_m    = (ABUS == c_ADDR_MASK) && !FLUSH;
  assign w_push_req = w_commit && |((r_cand ^ r_committed) & r_mask);

  always_ff @(posedge CLK) begin
    if (RESET)                r_mask <= '1;
    else if (w_sel_m && WE)   r_mask <= DBUS[NCH-1:0];
  end
`else
  assign w_sel_m    = 1'b0;
  assign w_push_req = w_commit && (r_cand != r_committed);
`endif

  assign w_ovr_set = w_push_req && w_full && !w_pop;

  io_event_fifo #(.W(NCH), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_data  (r_cand),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cand      <= IN;
      r_committed <= IN;
      r_cnt       <= '0;
      r_holding   <= 1'b0;
      r_ie        <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (IN != r_cand) begin
        r_cand    <= IN;
        r_cnt     <= '0;
        r_holding <= 1'b1;
      end else if (r_holding) begin
        if (r_cnt == c_CNT_LAST) r_holding <= 1'b0;
        else                     r_cnt     <= r_cnt + 1'b1;
      end
      if (w_commit) r_committed <= r_cand;
      if (w_wr_c)   r_ie        <= DBUS[IEBIT];
      // an overrun in the same cycle as a clearing write must not be lost
      if (w_ovr_set)                         r_ovr <= 1'b1;
      else if (w_wr_c && !DBUS[OVERRUNBIT])  r_ovr <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_d) begin
      w_rdata[NCH-1:0] = w_ready ? w_head : r_committed;
    end else if (w_sel_c) begin
      w_rdata[c_COUNT_LSB+3:c_COUNT_LSB] = sat_count4(32'(w_count));
      w_rdata[IEBIT]      = r_ie;
      w_rdata[OVERRUNBIT] = r_ovr;
      w_rdata[READYBIT]   = w_ready;
`ifdef DBNC_EDGE_MASK_EN
    end else if (w_sel_m) begin
      w_rdata[NCH-1:0] = r_mask;
`endif
    end
  end

  assign DBUS = (!WE && (w_sel_d || w_sel_c || w_sel_m)) ? w_rdata : {BITS{1'bz}};

  assign INTR  = r_ie;
  assign IRQ   = r_ie && w_ready;
  assign DEBUG = {r_committed, r_ie, r_ovr, w_ready, r_holding};

  assign w_unused_ok = ^{DBUS, w_sel_m};

endmodule
`default_nettype wire

// File: tb/tb_dbnc_event_dev.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dbnc_event_dev                                                |
// | Directed bench with a run-length event model; NCH=10, DEPTH=4,   |
// | DEBOUNCE_CYCLES=8.                                               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dbnc_event_dev;

  localparam int          DC    = 8;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hF000_0010;
  localparam logic [31:0] CTRL  = BASE + 32'h100;
  localparam logic [31:0] MASK  = BASE + 32'h200;

  logic        CLK = 1'b0;
  logic        RESET, WE, FLUSH;
  logic [31:0] ABUS;
  wire  [31:0] DBUS;
  logic [9:0]  IN;
  logic        INTR, IRQ;
  logic [13:0] DEBUG;
  logic [31:0] r_drv;
  logic        r_drv_en;

  int n_chk = 0;
  int n_err = 0;

  assign DBUS = r_drv_en ? r_drv : 32'bz;

  dbnc_event_dev #(.BITS(32), .BASE(BASE), .NCH(10), .DEPTH(DEPTH),
                   .DEBOUNCE_CYCLES(DC)) dut (
    .CLK(CLK), .RESET(RESET), .ABUS(ABUS), .DBUS(DBUS), .WE(WE),
    .FLUSH(FLUSH), .IN(IN), .INTR(INTR), .IRQ(IRQ), .DEBUG(DEBUG)
  );

  always #5 CLK = ~CLK;

  // model: an event is due once a changed value has been seen on DC+1 consecutive edges
  logic [9:0] q[$];
  logic [9:0] m_committed, m_prev, m_mask;
  int         m_run;
  bit         m_fromchg, m_ie, m_ovr, m_valid = 0;

  always @(posedge CLK) begin : model
    bit pop, push, commit, ovr_set;
    if (RESET) begin
      q.delete();
      m_ie = 0; m_ovr = 0; m_committed = IN; m_prev = IN;
      m_run = 1; m_fromchg = 0; m_mask = 10'h3FF; m_valid = 1;
    end else begin
      pop = (ABUS == BASE) && !FLUSH && !WE && (q.size() != 0);
      if (IN == m_prev) m_run++;
      else begin m_run = 1; m_fromchg = 1; end
      m_prev = IN;
      commit  = m_fromchg && (m_run == DC + 1);
      push    = commit && (((IN ^ m_committed) & m_mask) != 0);
      if (commit) m_committed = IN;
      ovr_set = 0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() == DEPTH) ovr_set = 1;
        else q.push_back(IN);
      end
      if ((ABUS == CTRL) && !FLUSH && WE) begin
        m_ie = DBUS[8];
        if (!DBUS[2]) m_ovr = 0;
      end
`ifdef DBNC_EDGE_MASK_EN
      if ((ABUS == MASK) && !FLUSH && WE) m_mask = DBUS[9:0];
`endif
      if (ovr_set) m_ovr = 1;
    end
  end

  function automatic bit model_rd(output logic [31:0] v);
    logic [3:0] c;
    v = '0;
    c = (q.size() > 15) ? 4'hF : 4'(q.size());
    if (FLUSH || WE) return 0;
    if (ABUS == BASE) begin
      v = (q.size() != 0) ? 32'(q[0]) : 32'(m_committed);
      return 1;
    end
    if (ABUS == CTRL) begin
      v = {16'h0, c, 3'b000, m_ie, 5'b00000, m_ovr, 1'b0, (q.size() != 0)};
      return 1;
    end
`ifdef DBNC_EDGE_MASK_EN
    if (ABUS == MASK) begin
      v = 32'(m_mask);
      return 1;
    end
`endif
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : compare
    logic [31:0] v;
    bit          hold, rdy;
    if (m_valid) begin
      rdy  = (q.size() != 0);
      hold = m_fromchg && (m_run <= DC);
      chk("debug", {18'b0, DEBUG}, {18'b0, m_committed, m_ie, m_ovr, rdy, hold});
      chk("irq",   {31'b0, IRQ},   {31'b0, m_ie && rdy});
      chk("intr",  {31'b0, INTR},  {31'b0, m_ie});
      if (model_rd(v)) chk("dbus", DBUS, v);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ABUS = 32'h0; WE = 1'b0; r_drv_en = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ABUS = a; WE = 1'b1; r_drv = d; r_drv_en = 1'b1;
    tick(1);
    idle();
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    ABUS = a; WE = 1'b0; r_drv_en = 1'b0;
    #1;
    chk(nm, DBUS, exp);
    tick(1);
    idle();
  endtask

  task automatic hold_in(input logic [9:0] v, input int n);
    IN = v;
    tick(n);
  endtask

  initial begin
    idle();
    r_drv = '0;
    RESET = 1'b1; IN = 10'h155;
    tick(3);
    RESET = 1'b0;
    tick(50);
    chk("rst_ready", {31'b0, DEBUG[1]}, 32'h0);
    chk("rst_irq",   {31'b0, IRQ}, 32'h0);
    rd("rst_data", BASE, 32'h155);

    hold_in(10'h000, 12);
    chk("ev0_ready", {31'b0, DEBUG[1]}, 32'h1);
    rd("ev0_data", BASE, 32'h000);
    wr(CTRL, 32'h100);
    chk("ie_set", {31'b0, INTR}, 32'h1);

    hold_in(10'h003, 8);
    chk("c8_ready", {31'b0, DEBUG[1]}, 32'h0);
    tick(1);
    chk("c9_ready", {31'b0, DEBUG[1]}, 32'h1);
    chk("c9_irq",   {31'b0, IRQ}, 32'h1);
    rd("ev3_data", BASE, 32'h003);
    chk("popped_ready", {31'b0, DEBUG[1]}, 32'h0);

    hold_in(10'h002, 5);
    hold_in(10'h003, 2);
    chk("glitch_hold", {31'b0, DEBUG[0]}, 32'h1);
    tick(8);
    chk("glitch_done", {18'b0, DEBUG}, {18'b0, 10'h003, 4'b1000});

    hold_in(10'h011, 10); hold_in(10'h022, 10); hold_in(10'h044, 10);
    hold_in(10'h088, 10); hold_in(10'h100, 10);
    chk("model_qsize", 32'(q.size()), 32'd4);
    rd("ovr_ctrl", CTRL, 32'h0000_4105);
    rd("ovr_d0", BASE, 32'h011); rd("ovr_d1", BASE, 32'h022);
    rd("ovr_d2", BASE, 32'h044); rd("ovr_d3", BASE, 32'h088);
    wr(CTRL, 32'h100);
    rd("ovr_clr", CTRL, 32'h0000_0100);

    hold_in(10'h201, 10); hold_in(10'h202, 10);
    hold_in(10'h204, 10); hold_in(10'h208, 10);
    hold_in(10'h210, 8);
    rd("pp_head", BASE, 32'h201);
    FLUSH = 1'b1; ABUS = BASE;
    tick(1);
    idle();
    rd("pp_ctrl", CTRL, 32'h0000_4101);
    rd("pp_d0", BASE, 32'h202); rd("pp_d1", BASE, 32'h204);
    rd("pp_d2", BASE, 32'h208); rd("pp_d3", BASE, 32'h210);

    wr(BASE, 32'h3FF);
    wr(CTRL, 32'h004);
    chk("ie_clr", {31'b0, INTR}, 32'h0);
    rd("ctrl_zero", CTRL, 32'h0);

    hold_in(10'h301, 10); hold_in(10'h302, 10);
    hold_in(10'h304, 10); hold_in(10'h308, 10);
    hold_in(10'h310, 8);
    wr(CTRL, 32'h000);
    rd("set_wins", CTRL, 32'h0000_4005);
    rd("sw_d0", BASE, 32'h301); rd("sw_d1", BASE, 32'h302);
    rd("sw_d2", BASE, 32'h304); rd("sw_d3", BASE, 32'h308);
    rd("sw_commit", BASE, 32'h310);

`ifdef DBNC_EDGE_MASK_EN
    wr(MASK, 32'h002);
    rd("mask_rd", MASK, 32'h002);
    hold_in(10'h311, 10);
    chk("mask_nopush", {31'b0, DEBUG[1]}, 32'h0);
    rd("mask_commit", BASE, 32'h311);
    hold_in(10'h313, 10);
    chk("mask_push", {31'b0, DEBUG[1]}, 32'h1);
    rd("mask_data", BASE, 32'h313);
`endif

    hold_in(10'h000, 12);
    chk("pre_rst_ready", {31'b0, DEBUG[1]}, 32'h1);
    hold_in(10'h005, 4);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    tick(20);
    chk("mid_rst", {18'b0, DEBUG}, {18'b0, 10'h005, 4'b0000});
    rd("mid_rst_data", BASE, 32'h005);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
